// File: rtl/req_pend_dispatch8.sv
// Sticky 8-channel request register feeding an external 8-to-3 priority encoder,
// dispatching the winning code over valid/ready. Option macro: REQ_EDGE_DETECT_EN.
module req_pend_dispatch8 #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       req,
    input  logic [7:0]       mask,
    output logic [7:0]       pend,
    input  logic [2:0]       enc_y,
    input  logic             enc_f,
    output logic             valid,
    output logic [2:0]       code,
    input  logic             ready,
    output logic [7:0]       ovf,
    input  logic             clr_ovf,
    output logic [CNT_W-1:0] svc_cnt
);
    typedef enum logic {IDLE, OFFER} state_t;

    state_t     state;
    logic [7:0] pend_r;
    logic [7:0] set_v;
    logic [7:0] clr_v;

    assign clr_v = (state == OFFER && ready) ? (8'd1 << code) : 8'd0;
    assign pend  = pend_r & mask;

`ifdef REQ_EDGE_DETECT_EN
    logic [7:0] req_d;

    assign set_v = req & ~req_d;

    // A new event landing on a still-pending, not-cleared bit is lost work.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_d <= 8'd0;
            ovf   <= 8'd0;
        end else begin
            req_d <= req;
            ovf   <= (clr_ovf ? 8'd0 : ovf) | (set_v & pend_r & ~clr_v);
        end
    end
`else
    logic unused_clr_ovf;

    assign set_v          = req;
    assign ovf            = 8'd0;
    assign unused_clr_ovf = clr_ovf;
`endif

    // Masking only hides bits from the encoder; accumulation continues.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_r <= 8'd0;
        end else begin
            pend_r <= set_v | (pend_r & ~clr_v);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            valid   <= 1'b0;
            code    <= 3'd0;
            svc_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (enc_f) begin
                        code  <= enc_y;
                        valid <= 1'b1;
                        state <= OFFER;
                    end
                end
                OFFER: begin
                    if (ready) begin
                        valid   <= 1'b0;
                        svc_cnt <= svc_cnt + CNT_W'(1);
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_req_pend_dispatch8.sv
// Bench for req_pend_dispatch8: encoder model plus a dispatch scoreboard.
// Runs in either mode depending on REQ_EDGE_DETECT_EN.
module tb_req_pend_dispatch8;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic [7:0] mask;
    logic [7:0] pend;
    logic [2:0] enc_y;
    logic       enc_f;
    logic       valid;
    logic [2:0] code;
    logic       ready;
    logic [7:0] ovf;
    logic       clr_ovf;
    logic [7:0] svc_cnt;

    int total = 0;
    int bad = 0;
    int exp_cnt = 0;
    logic [2:0] exp_q[$];
    logic [2:0] obs_q[$];

`ifdef REQ_EDGE_DETECT_EN
    localparam logic [7:0] OVF_EXP = 8'h08;
`else
    localparam logic [7:0] OVF_EXP = 8'h00;
`endif

    req_pend_dispatch8 #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst), .req(req), .mask(mask), .pend(pend),
        .enc_y(enc_y), .enc_f(enc_f), .valid(valid), .code(code),
        .ready(ready), .ovf(ovf), .clr_ovf(clr_ovf), .svc_cnt(svc_cnt)
    );

    always #5 clk = ~clk;

    // lowest-index-wins encoder
    always_comb begin
        enc_f = |pend;
        enc_y = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (pend[i]) enc_y = 3'(i);
    end

    always @(negedge clk)
        if (!rst && valid && ready) obs_q.push_back(code);

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; req = 8'h00; mask = 8'hFF; ready = 1'b1; clr_ovf = 1'b0;
        tick(2);
        total++; if (pend !== 8'h00) begin bad++; $display("FAIL rst_pend got %h want 00", pend); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL rst_valid got %b want 0", valid); end
        total++; if (code !== 3'd0) begin bad++; $display("FAIL rst_code got %0d want 0", code); end
        total++; if (ovf !== 8'h00) begin bad++; $display("FAIL rst_ovf got %h want 00", ovf); end
        total++; if (svc_cnt !== 8'd0) begin bad++; $display("FAIL rst_cnt got %0d want 0", svc_cnt); end
        rst = 1'b0;
        exp_cnt = 0;
        tick(1);
    endtask

    task automatic test_single;
        logic [2:0] e, o;
        int n;
        req = 8'h04;
        tick(1);
        req = 8'h00;
        total++; if (pend !== 8'h04) begin bad++; $display("FAIL single_pend got %h want 04", pend); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL single_early got %b want 0", valid); end
        tick(1);
        exp_q.push_back(3'd2); exp_cnt++;
        total++; if (valid !== 1'b1 || code !== 3'd2) begin bad++; $display("FAIL single_offer got v=%b c=%0d want v=1 c=2", valid, code); end
        tick(1);
        total++; if (pend !== 8'h00 || valid !== 1'b0) begin bad++; $display("FAIL single_clear got p=%h v=%b want p=00 v=0", pend, valid); end
        total++; if (svc_cnt !== 8'(exp_cnt)) begin bad++; $display("FAIL single_cnt got %0d want %0d", svc_cnt, exp_cnt); end
        tick(3);
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL single_idle got %b want 0", valid); end
        n = 0;
        while (obs_q.size() < exp_q.size() && n < 100) begin tick(1); n++; end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); total++;
            if (obs_q.size() == 0) begin bad++; $display("FAIL single_sb got none want %0d", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin bad++; $display("FAIL single_sb got %0d want %0d", o, e); end end
        end
        total++; if (obs_q.size() != 0) begin bad++; $display("FAIL single_extra got %0d extra want 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_priority;
        logic [2:0] e, o;
        int n;
        req = 8'h81;
        tick(1);
        req = 8'h00;
        total++; if (pend !== 8'h81) begin bad++; $display("FAIL prio_pend got %h want 81", pend); end
        exp_q.push_back(3'd0); exp_q.push_back(3'd7); exp_cnt += 2;
        tick(1);
        total++; if (valid !== 1'b1 || code !== 3'd0) begin bad++; $display("FAIL prio_first got v=%b c=%0d want v=1 c=0", valid, code); end
        tick(1);
        total++; if (valid !== 1'b0 || pend !== 8'h80) begin bad++; $display("FAIL prio_gap got v=%b p=%h want v=0 p=80", valid, pend); end
        tick(1);
        total++; if (valid !== 1'b1 || code !== 3'd7) begin bad++; $display("FAIL prio_second got v=%b c=%0d want v=1 c=7", valid, code); end
        tick(3);
        n = 0;
        while (obs_q.size() < exp_q.size() && n < 100) begin tick(1); n++; end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); total++;
            if (obs_q.size() == 0) begin bad++; $display("FAIL prio_sb got none want %0d", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin bad++; $display("FAIL prio_sb got %0d want %0d", o, e); end end
        end
        total++; if (obs_q.size() != 0) begin bad++; $display("FAIL prio_extra got %0d extra want 0", obs_q.size()); obs_q.delete(); end
        total++; if (pend !== 8'h00 || svc_cnt !== 8'(exp_cnt)) begin bad++; $display("FAIL prio_end got p=%h cnt=%0d want p=00 cnt=%0d", pend, svc_cnt, exp_cnt); end
    endtask

    task automatic test_no_preempt;
        logic [2:0] e, o;
        int n;
        ready = 1'b0;
        req = 8'h20;
        tick(1);
        req = 8'h00;
        tick(1);
        req = 8'h01;
        tick(1);
        req = 8'h00;
        tick(3);
        total++; if (valid !== 1'b1 || code !== 3'd5) begin bad++; $display("FAIL hold_code got v=%b c=%0d want v=1 c=5", valid, code); end
        total++; if (pend !== 8'h21) begin bad++; $display("FAIL hold_pend got %h want 21", pend); end
        exp_q.push_back(3'd5); exp_q.push_back(3'd0); exp_cnt += 2;
        ready = 1'b1;
        tick(6);
        n = 0;
        while (obs_q.size() < exp_q.size() && n < 100) begin tick(1); n++; end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); total++;
            if (obs_q.size() == 0) begin bad++; $display("FAIL hold_sb got none want %0d", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin bad++; $display("FAIL hold_sb got %0d want %0d", o, e); end end
        end
        total++; if (obs_q.size() != 0) begin bad++; $display("FAIL hold_extra got %0d extra want 0", obs_q.size()); obs_q.delete(); end
        total++; if (pend !== 8'h00 || svc_cnt !== 8'(exp_cnt)) begin bad++; $display("FAIL hold_end got p=%h cnt=%0d want p=00 cnt=%0d", pend, svc_cnt, exp_cnt); end
    endtask

    task automatic test_mask;
        logic [2:0] e, o;
        int n;
        mask = 8'hFE;
        req = 8'h21;
        tick(1);
        req = 8'h00;
        total++; if (pend !== 8'h20) begin bad++; $display("FAIL mask_pend got %h want 20", pend); end
        exp_q.push_back(3'd5); exp_cnt++;
        tick(5);
        total++; if (pend !== 8'h00 || valid !== 1'b0) begin bad++; $display("FAIL mask_hidden got p=%h v=%b want p=00 v=0", pend, valid); end
        mask = 8'hFF;
        #1;
        total++; if (pend !== 8'h01) begin bad++; $display("FAIL mask_kept got %h want 01", pend); end
        exp_q.push_back(3'd0); exp_cnt++;
        tick(4);
        ready = 1'b0;
        req = 8'h08;
        tick(1);
        req = 8'h00;
        tick(1);
        total++; if (valid !== 1'b1 || code !== 3'd3) begin bad++; $display("FAIL mask_drop_offer got v=%b c=%0d want v=1 c=3", valid, code); end
        mask = 8'hF7;
        #1;
        total++; if (pend !== 8'h00) begin bad++; $display("FAIL mask_drop_pend got %h want 00", pend); end
        ready = 1'b1;
        exp_q.push_back(3'd3); exp_cnt++;
        tick(3);
        mask = 8'hFF;
        #1;
        total++; if (pend !== 8'h00 || valid !== 1'b0) begin bad++; $display("FAIL mask_drop_done got p=%h v=%b want p=00 v=0", pend, valid); end
        n = 0;
        while (obs_q.size() < exp_q.size() && n < 100) begin tick(1); n++; end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); total++;
            if (obs_q.size() == 0) begin bad++; $display("FAIL mask_sb got none want %0d", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin bad++; $display("FAIL mask_sb got %0d want %0d", o, e); end end
        end
        total++; if (obs_q.size() != 0) begin bad++; $display("FAIL mask_extra got %0d extra want 0", obs_q.size()); obs_q.delete(); end
        total++; if (svc_cnt !== 8'(exp_cnt)) begin bad++; $display("FAIL mask_cnt got %0d want %0d", svc_cnt, exp_cnt); end
    endtask

    task automatic test_ovf;
        logic [2:0] e, o;
        int n;
        ready = 1'b0;
        req = 8'h08;
        tick(1);
        req = 8'h00;
        tick(2);
        req = 8'h08;
        tick(1);
        req = 8'h00;
        total++; if (ovf !== OVF_EXP) begin bad++; $display("FAIL ovf_set got %h want %h", ovf, OVF_EXP); end
        tick(2);
        total++; if (ovf !== OVF_EXP) begin bad++; $display("FAIL ovf_sticky got %h want %h", ovf, OVF_EXP); end
        clr_ovf = 1'b1;
        tick(1);
        clr_ovf = 1'b0;
        total++; if (ovf !== 8'h00) begin bad++; $display("FAIL ovf_clr got %h want 00", ovf); end
        exp_q.push_back(3'd3); exp_cnt++;
        ready = 1'b1;
        tick(5);
        n = 0;
        while (obs_q.size() < exp_q.size() && n < 100) begin tick(1); n++; end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); total++;
            if (obs_q.size() == 0) begin bad++; $display("FAIL ovf_sb got none want %0d", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin bad++; $display("FAIL ovf_sb got %0d want %0d", o, e); end end
        end
        total++; if (obs_q.size() != 0) begin bad++; $display("FAIL ovf_extra got %0d extra want 0", obs_q.size()); obs_q.delete(); end
        total++; if (pend !== 8'h00 || svc_cnt !== 8'(exp_cnt)) begin bad++; $display("FAIL ovf_end got p=%h cnt=%0d want p=00 cnt=%0d", pend, svc_cnt, exp_cnt); end
    endtask

    task automatic test_rst_mid_offer;
        logic [2:0] e, o;
        int n;
        ready = 1'b0;
        req = 8'h10;
        tick(2);
        total++; if (valid !== 1'b1 || code !== 3'd4) begin bad++; $display("FAIL rstmid_offer got v=%b c=%0d want v=1 c=4", valid, code); end
        #3 rst = 1'b1;
        #1;
        total++; if (valid !== 1'b0 || code !== 3'd0) begin bad++; $display("FAIL rstmid_valid got v=%b c=%0d want v=0 c=0", valid, code); end
        total++; if (pend !== 8'h00 || ovf !== 8'h00 || svc_cnt !== 8'd0) begin bad++; $display("FAIL rstmid_state got p=%h o=%h cnt=%0d want 00 00 0", pend, ovf, svc_cnt); end
        exp_cnt = 0;
        exp_q.delete();
        obs_q.delete();
        tick(1);
        rst = 1'b0;
        ready = 1'b1;
        tick(1);
        req = 8'h00;
        total++; if (pend !== 8'h10) begin bad++; $display("FAIL rstmid_repend got %h want 10", pend); end
        exp_q.push_back(3'd4); exp_cnt++;
        tick(4);
        n = 0;
        while (obs_q.size() < exp_q.size() && n < 100) begin tick(1); n++; end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); total++;
            if (obs_q.size() == 0) begin bad++; $display("FAIL rstmid_sb got none want %0d", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin bad++; $display("FAIL rstmid_sb got %0d want %0d", o, e); end end
        end
        total++; if (obs_q.size() != 0) begin bad++; $display("FAIL rstmid_extra got %0d extra want 0", obs_q.size()); obs_q.delete(); end
        total++; if (svc_cnt !== 8'(exp_cnt)) begin bad++; $display("FAIL rstmid_cnt got %0d want %0d", svc_cnt, exp_cnt); end
    endtask

`ifdef REQ_EDGE_DETECT_EN
    task automatic test_hold_once;
        logic [2:0] e, o;
        int n;
        ready = 1'b1;
        req = 8'h40;
        exp_q.push_back(3'd6); exp_cnt++;
        tick(20);
        total++; if (svc_cnt !== 8'(exp_cnt) || valid !== 1'b0) begin bad++; $display("FAIL once_cnt got cnt=%0d v=%b want cnt=%0d v=0", svc_cnt, valid, exp_cnt); end
        req = 8'h00;
        tick(3);
        n = 0;
        while (obs_q.size() < exp_q.size() && n < 100) begin tick(1); n++; end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); total++;
            if (obs_q.size() == 0) begin bad++; $display("FAIL once_sb got none want %0d", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin bad++; $display("FAIL once_sb got %0d want %0d", o, e); end end
        end
        total++; if (obs_q.size() != 0) begin bad++; $display("FAIL once_extra got %0d extra want 0", obs_q.size()); obs_q.delete(); end
    endtask
`else
    task automatic test_level_wrap;
        logic [2:0] e, o;
        int n;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        exp_cnt = 0;
        ready = 1'b1;
        req = 8'h02;
        for (int i = 0; i < 256; i++) exp_q.push_back(3'd1);
        exp_cnt = 256;
        tick(4);
        total++; if (valid !== 1'b1 || code !== 3'd1) begin bad++; $display("FAIL wrap_offer got v=%b c=%0d want v=1 c=1", valid, code); end
        tick(1);
        total++; if (valid !== 1'b0 || svc_cnt !== 8'd2) begin bad++; $display("FAIL wrap_gap got v=%b cnt=%0d want v=0 cnt=2", valid, svc_cnt); end
        tick(506);
        total++; if (svc_cnt !== 8'd255) begin bad++; $display("FAIL wrap_255 got %0d want 255", svc_cnt); end
        req = 8'h00;
        tick(2);
        total++; if (svc_cnt !== 8'd0) begin bad++; $display("FAIL wrap_zero got %0d want 0", svc_cnt); end
        tick(3);
        n = 0;
        while (obs_q.size() < exp_q.size() && n < 100) begin tick(1); n++; end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); total++;
            if (obs_q.size() == 0) begin bad++; $display("FAIL wrap_sb got none want %0d", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin bad++; $display("FAIL wrap_sb got %0d want %0d", o, e); end end
        end
        total++; if (obs_q.size() != 0) begin bad++; $display("FAIL wrap_extra got %0d extra want 0", obs_q.size()); obs_q.delete(); end
        total++; if (pend !== 8'h00 || svc_cnt !== 8'(exp_cnt)) begin bad++; $display("FAIL wrap_end got p=%h cnt=%0d want p=00 cnt=%0d", pend, svc_cnt, 8'(exp_cnt)); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_no_preempt();
        test_mask();
        test_ovf();
        test_rst_mid_offer();
`ifdef REQ_EDGE_DETECT_EN
        test_hold_once();
`else
        test_level_wrap();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/req_pend_dispatch8.md
# req_pend_dispatch8

Sticky 8-channel request register and service dispatcher around the 8-to-3 priority encoder. It captures request events into a pending vector and drives that vector to the encoder's 8-bit input. It reads back the encoder's 3-bit code and valid flag, then offers the winning code to a consumer over a valid/ready handshake. The pending bit of a channel is cleared when its code is accepted, so channels are serviced one at a time in encoder priority order (lowest index first).

## Interface
- CNT_W, 8 — width of the serviced-request counter; wraps modulo 2^CNT_W.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  8  raw request lines from sources, synchronous to clk.
- mask  in  8  per-channel enable; 1 = channel visible to encoder.
- pend  out  8  masked pending vector (pend_r & mask); connects to encoder input.
- enc_y  in  3  encoder code output.
- enc_f  in  1  encoder "any input active" flag.
- valid  out  1  dispatched code is being offered.
- code  out  3  dispatched channel index; stable while valid=1.
- ready  in  1  consumer accepts code when valid&ready at a clock edge.
- ovf  out  8  sticky per-channel overflow flags.
- clr_ovf  in  1  synchronous clear of all ovf bits.
- svc_cnt  out  CNT_W  count of accepted dispatches.

## Operation
- Internal pending register pend_r[7:0]. Set condition per bit i (see Configuration) is set_i; clear condition is clr_i = (state==OFFER) & ready & (code==i).
- Update: pend_r[i] <= set_i | (pend_r[i] & ~clr_i). Set wins over a same-cycle clear.
- Masked-off channels keep accumulating in pend_r; they are dispatched once unmasked.
- FSM with 2 states:
  - IDLE: valid=0. If enc_f=1 at edge, code <= enc_y, go to OFFER.
  - OFFER: valid=1, code held. On valid&ready: clear pend_r[code], svc_cnt += 1, go to IDLE. Otherwise stay; ready may stay low indefinitely.
- The code is frozen on entering OFFER. A higher-priority request arriving during OFFER does not preempt it; it wins at the next IDLE sample.
- If the mask bit of the offered channel drops during OFFER, the offer still completes normally.
- ovf[i] sets when set_i=1 while pend_r[i]=1 and clr_i=0. This requires an event mode, so ovf is always 0 in level mode.
- ovf bits hold until clr_ovf=1. If clr_ovf and an overflow event occur in the same cycle, the set wins.
- Reset values: pend_r=0, pend=0, valid=0, code=0, ovf=0, svc_cnt=0, state=IDLE, req_d=0.

## Timing
- Request event sampled at edge k sets pend_r at edge k; pend/enc_f update combinationally after edge k.
- FSM samples enc_f at edge k+1, so valid=1 after edge k+1. Request-to-valid latency is 2 edges.
- Acceptance at edge m clears the pend bit and returns the FSM to IDLE. The next pending code is sampled at edge m+1 and valid is high again after it.
- Maximum throughput is one dispatch per 2 cycles, and valid is low for at least 1 cycle between offers.
- rst asserted mid-OFFER drops valid immediately (asynchronous); the in-flight code is lost.
- req_d resets to 0, so in event mode a req held high across reset release registers an event at the first clock edge.

## Configuration
- REQ_EDGE_DETECT_EN defined (event mode): set_i = req[i] & ~req_d[i], where req_d is req registered one cycle. A held-high request produces exactly one dispatch, and ovf is active.
- REQ_EDGE_DETECT_EN undefined (level mode): set_i = req[i]. A held-high request re-pends immediately after each clear and is re-dispatched every 2 cycles. req_d is not built and ovf is tied to 0.

## Test plan
- Event mode, mask=FF, ready=1, req 00→04 at edge 1: valid high after edge 2 with code=2; pend[2] clears at edge 3; svc_cnt=1; valid then stays low.
- Event mode, req=81 rising together, ready=1: dispatches code 0, then code 7, with valid low for 1 cycle between them; svc_cnt=2; pend=00 at the end.
- Event mode, ready=0, req[3] pulsed twice while pending: ovf=08. clr_ovf=1 then gives ovf=00. Raising ready then yields a single dispatch of code 3.
- mask=FE with req[0] and req[5] events: code 5 is dispatched first. Setting mask=FF then dispatches code 0.
- rst pulsed while valid=1 with code=4: valid drops immediately; pend, ovf and svc_cnt read 0. If req[4] is held high through reset release in event mode, it is re-dispatched.
- Level mode, req[1] held high, ready=1: code 1 is dispatched every 2 cycles; svc_cnt wraps from 255 to 0 with CNT_W=8.
